// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Purpose  : Execution-stage ALU; single-cycle logic/arith, iterative MUL/DIV
//            with start/busy/done handshake and MIPS-style HI/LO results.
// Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int         c_CNT_W  = $clog2(WIDTH + 1);
    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_SLT = 3'd4;
    localparam logic [2:0] c_OP_MUL = 3'd5;
    localparam logic [2:0] c_OP_DIV = 3'd6;
    localparam logic [2:0] c_OP_NOP = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nx;
    logic [WIDTH-1:0]   r_lo, w_lo_nx;
    logic [WIDTH-1:0]   r_hi, w_hi_nx;
    logic               r_zero, w_zero_nx;
    logic               r_dbz, w_dbz_nx;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nx;
    logic               r_is_div, w_is_div_nx;
    // r_acc: partial product high half / partial remainder
    // r_q  : multiplier being shifted out / dividend becoming the quotient
    logic [WIDTH-1:0]   r_acc, w_acc_nx;
    logic [WIDTH-1:0]   r_q, w_q_nx;
    logic [WIDTH-1:0]   r_opnd, w_opnd_nx;

    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_it_hi;
    logic [WIDTH-1:0]   w_it_lo;

    always_comb begin
        w_alu = '0;
        case (op)
            c_OP_ADD: w_alu = a + b;
            c_OP_SUB: w_alu = a - b;
            c_OP_AND: w_alu = a & b;
            c_OP_OR:  w_alu = a | b;
            c_OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default:  w_alu = '0;
        endcase
    end

    // One shift-add or restoring-subtract step per cycle.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_div_sh   = {r_acc, r_q[WIDTH-1]};
        w_div_diff = w_div_sh - {1'b0, r_opnd};
        w_div_ge   = ~w_div_diff[WIDTH];
        if (r_is_div) begin
            w_it_hi = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
            w_it_lo = {r_q[WIDTH-2:0], w_div_ge};
        end else begin
            w_it_hi = w_mul_sum[WIDTH:1];
            w_it_lo = {w_mul_sum[0], r_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_lo_nx     = r_lo;
        w_hi_nx     = r_hi;
        w_zero_nx   = r_zero;
        w_dbz_nx    = r_dbz;
        w_cnt_nx    = r_cnt;
        w_is_div_nx = r_is_div;
        w_acc_nx    = r_acc;
        w_q_nx      = r_q;
        w_opnd_nx   = r_opnd;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (op == c_OP_NOP) begin
                        w_dbz_nx   = 1'b0;
                        w_state_nx = S_DONE;
                    end else if (op == c_OP_DIV && b == '0) begin
                        w_lo_nx    = '1;
                        w_hi_nx    = a;
                        w_zero_nx  = 1'b0;
                        w_dbz_nx   = 1'b1;
                        w_state_nx = S_DONE;
                    end else if (op == c_OP_MUL || op == c_OP_DIV) begin
                        w_is_div_nx = (op == c_OP_DIV);
                        w_acc_nx    = '0;
                        w_q_nx      = (op == c_OP_DIV) ? a : b;
                        w_opnd_nx   = (op == c_OP_DIV) ? b : a;
                        w_cnt_nx    = '0;
                        w_state_nx  = S_CALC;
                    end else begin
                        w_lo_nx    = w_alu;
                        w_zero_nx  = (w_alu == '0);
                        w_dbz_nx   = 1'b0;
                        w_state_nx = S_DONE;
                    end
                end
            end
            S_CALC: begin
                w_acc_nx = w_it_hi;
                w_q_nx   = w_it_lo;
                w_cnt_nx = r_cnt + 1'b1;
                // The final step writes the results directly so done follows next cycle.
                if (r_cnt == c_CNT_W'(WIDTH - 1)) begin
                    w_lo_nx    = w_it_lo;
                    w_hi_nx    = w_it_hi;
                    w_zero_nx  = (w_it_lo == '0);
                    w_dbz_nx   = 1'b0;
                    w_state_nx = S_DONE;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b1;
            r_dbz    <= 1'b0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_acc    <= '0;
            r_q      <= '0;
            r_opnd   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_lo     <= w_lo_nx;
            r_hi     <= w_hi_nx;
            r_zero   <= w_zero_nx;
            r_dbz    <= w_dbz_nx;
            r_cnt    <= w_cnt_nx;
            r_is_div <= w_is_div_nx;
            r_acc    <= w_acc_nx;
            r_q      <= w_q_nx;
            r_opnd   <= w_opnd_nx;
        end
    end

    assign result_lo   = r_lo;
    assign result_hi   = r_hi;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;
    assign busy        = (r_state == S_CALC);
    assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Purpose  : Directed vector table plus hand sequences for alu_multicycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] result_lo, result_hi;
    logic        zero, busy, done, div_by_zero;

    int n_pass  = 0;
    int n_total = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .zero        (zero),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        dbz;
        int          lat;
        int          glitch;
    } vec_t;

    localparam int NV = 17;
    vec_t tv [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat = 0;
        int busy_n = 0;
        bit both = 0;
        bit got = 0;
        op = v.op; a = v.a; b = v.b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        while (lat < 100 && !got) begin
            @(negedge clk);
            lat++;
            if (v.glitch != 0 && lat == v.glitch) begin
                start = 1'b1; op = 3'd0;
            end
            if (v.glitch != 0 && lat == v.glitch + 1) start = 1'b0;
            if (busy) busy_n++;
            if (busy && done) both = 1'b1;
            if (done) got = 1'b1;
        end
        chk({nm, "_latency"}, lat, v.lat);
        chk({nm, "_busy_cycles"}, busy_n, v.lat - 1);
        chk({nm, "_busy_with_done"}, {31'd0, both}, 32'd0);
        chk({nm, "_lo"}, result_lo, v.lo);
        chk({nm, "_hi"}, result_hi, v.hi);
        chk({nm, "_zero"}, {31'd0, zero}, {31'd0, v.z});
        chk({nm, "_dbz"}, {31'd0, div_by_zero}, {31'd0, v.dbz});
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int seen;
        //        op    a             b             lo            hi            z     dbz   lat glitch
        tv[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1,  0};
        tv[1]  = '{3'd1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h00000000, 1'b0, 1'b0, 1,  0};
        tv[2]  = '{3'd2, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 32'h00000000, 1'b0, 1'b0, 1,  0};
        tv[3]  = '{3'd3, 32'h0F000000, 32'h000000F0, 32'h0F0000F0, 32'h00000000, 1'b0, 1'b0, 1,  0};
        tv[4]  = '{3'd4, 32'h80000000, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1,  0};
        tv[5]  = '{3'd4, 32'h00000001, 32'h80000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1,  0};
        tv[6]  = '{3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 33, 5};
        tv[7]  = '{3'd0, 32'h00000002, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1,  0};
        tv[8]  = '{3'd6, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 33, 0};
        tv[9]  = '{3'd7, 32'h12345678, 32'h0,        32'd14,       32'd2,        1'b0, 1'b0, 1,  0};
        tv[10] = '{3'd6, 32'd100,      32'd0,        32'hFFFFFFFF, 32'd100,      1'b0, 1'b1, 1,  0};
        tv[11] = '{3'd7, 32'h0,        32'h0,        32'hFFFFFFFF, 32'd100,      1'b0, 1'b0, 1,  0};
        tv[12] = '{3'd5, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 33, 0};
        tv[13] = '{3'd6, 32'd7,        32'd100,      32'd0,        32'd7,        1'b1, 1'b0, 33, 0};
        tv[14] = '{3'd6, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 33, 12};
        tv[15] = '{3'd2, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 32'd0,        1'b1, 1'b0, 1,  0};
        tv[16] = '{3'd5, 32'd12345,    32'd678,      32'h007FB6F6, 32'd0,        1'b0, 1'b0, 33, 0};

        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_lo", result_lo, 32'h0);
        chk("rst_hi", result_hi, 32'h0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);

        for (int i = 0; i < NV; i++) run_vec(tv[i], $sformatf("v%0d", i));

        // start held through the done cycle must not launch a second op
        op = 3'd0; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        op = 3'd1; a = 32'd9; b = 32'd1;
        @(negedge clk);
        chk("hold_done", {31'd0, done}, 32'd1);
        chk("hold_lo", result_lo, 32'd5);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("hold_no_redo", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("hold_no_redo2", {31'd0, done}, 32'd0);
        chk("hold_lo_kept", result_lo, 32'd5);

        // reset in the middle of a divide
        op = 3'd6; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_lo", result_lo, 32'd0);
        chk("abort_hi", result_hi, 32'd0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort_no_done", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Execution-stage ALU that sits directly downstream of the ALU control decoder and consumes its 3-bit `op` code.
- Single-cycle ops (add, sub, and, or, slt, nop) complete in one cycle.
- MUL (shift-add) and DIV (restoring) are iterative, producing MIPS-style HI/LO results.
- A start/busy/done handshake lets the control unit stall the pipeline while an iterative op runs.

Parameters:
- WIDTH, 32, operand and result width; also the iteration count for MUL and DIV.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 MUL, 6 DIV, 7 NOP
- a  input  WIDTH  operand A (rs)
- b  input  WIDTH  operand B (rt/imm)
- result_lo  output  WIDTH  main result; product low half; quotient
- result_hi  output  WIDTH  product high half; remainder; otherwise unchanged
- zero  output  1  registered, result_lo==0 for the last completed op
- busy  output  1  high while an iterative op is in progress
- done  output  1  one-cycle completion pulse
- div_by_zero  output  1  set by DIV with b==0; cleared by next completed op

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, result_lo=0, result_hi=0, zero=1, busy=0, done=0, div_by_zero=0, iteration counter=0.
- Reset asserted mid-operation aborts the op; no done pulse follows.
- States are IDLE, CALC, DONE.
- IDLE, start=1, op in {0,1,2,3,4,7}:
  - Compute at this edge; registers update; go to DONE.
  - done is visible in the next cycle (latency 1).
- IDLE, start=1, op=5 or op=6 with b!=0:
  - Latch a and b; counter=0; busy=1; go to CALC.
- IDLE, start=1, op=6 with b==0:
  - result_lo = all ones; result_hi = a; div_by_zero=1; go to DONE (latency 1).
- CALC:
  - One iteration per cycle; counter increments.
  - After WIDTH iterations, write the results, set busy=0, go to DONE.
  - Total latency from start edge to done-high cycle is WIDTH+1 cycles.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in CALC and DONE, and the latched operands are unaffected.
- Earliest accepted back-to-back start is the cycle after done.
- op, a and b may change freely after the start edge.
- Arithmetic:
  - ADD/SUB: modulo 2^WIDTH; no overflow trap; result_hi unchanged.
  - AND/OR: bitwise.
  - SLT: signed two's-complement compare; result_lo = 1 or 0.
  - MUL: unsigned WIDTH×WIDTH; {result_hi, result_lo} = full 2×WIDTH product.
  - DIV: unsigned; result_lo = quotient, result_hi = remainder.
  - NOP: result_lo, result_hi and zero hold their values; done still pulses; div_by_zero clears.
- zero is updated together with result_lo on every completed op except NOP.
- Outputs hold their values between ops.
- busy is never high in the same cycle as done.

Test Plan:
- Reset while idle, then release:
  - result_lo=0, result_hi=0, zero=1, done=0, busy=0.
- ADD, a=0xFFFFFFFF, b=1, start one cycle:
  - Next cycle: done=1, result_lo=0, zero=1.
- SUB, a=5, b=7:
  - result_lo=0xFFFFFFFE, zero=0.
- SLT, a=0x80000000, b=1:
  - result_lo=1.
- SLT, a=1, b=0x80000000:
  - result_lo=0.
- MUL, a=0xFFFFFFFF, b=0xFFFFFFFF:
  - busy for 32 cycles; done in cycle 33 after start.
  - result_hi=0xFFFFFFFE, result_lo=0x00000001.
  - A second start pulsed during busy is ignored.
- DIV, a=100, b=7:
  - After 33 cycles: result_lo=14, result_hi=2, div_by_zero=0.
- DIV, a=100, b=0:
  - Next cycle: done=1, result_lo=0xFFFFFFFF, result_hi=100, div_by_zero=1.
- DIV, a=100, b=7, with reset asserted at cycle 10 of CALC:
  - Immediately busy=0 and result_lo/result_hi=0.
  - No done pulse ever appears.
